// File: rtl/nfc_acg_command_executor.sv
// nfc_acg_command_executor
// Consumer end of the ACG command bus. Takes one atomic command (opcode, way,
// CA bytes, word count), streams the CA bytes to the primitive layer, then
// passes write data down or read data up with valid/ready on both sides.
//
// Build option: NFC_ACG_LAST_CHECK_EN
//   defined   - during the write phase, a beat whose iACG_WriteLast disagrees
//               with the locally generated last flag sets the sticky error.
//               The transfer still runs to the latched word count.
//   undefined - iACG_WriteLast is ignored; only an illegal opcode sets error.
//
// state | meaning
// IDLE  | waiting for a command, oACG_Ready high
// CA    | sending latched CA bytes, one per iPM_CAReady handshake
// WDAT  | write data pass-through, counting beats up to NumOfData
// RDAT  | read data pass-through, counting beats up to NumOfData
// DONE  | one-cycle completion pulse, then back to IDLE

module nfc_acg_command_executor #(
   parameter int NumberOfWays = 4
) (
   input  logic                    iSystemClock,
   input  logic                    iReset,
   input  logic [7:0]              iACG_Command,
   input  logic [2:0]              iACG_CommandOption,
   input  logic [NumberOfWays-1:0] iACG_TargetWay,
   input  logic [15:0]             iACG_NumOfData,
   input  logic                    iACG_CASelect,
   input  logic [39:0]             iACG_CAData,
   input  logic [15:0]             iACG_WriteData,
   input  logic                    iACG_WriteLast,
   input  logic                    iACG_WriteValid,
   output logic                    oACG_WriteReady,
   output logic [15:0]             oACG_ReadData,
   output logic                    oACG_ReadLast,
   output logic                    oACG_ReadValid,
   input  logic                    iACG_ReadReady,
   output logic                    oACG_Ready,
   output logic                    oACG_Done,
   output logic                    oACG_Error,
   output logic [NumberOfWays-1:0] oPM_TargetWay,
   output logic                    oPM_CAValid,
   output logic [7:0]              oPM_CAData,
   output logic                    oPM_CAIsCmd,
   input  logic                    iPM_CAReady,
   output logic [15:0]             oPM_WriteData,
   output logic                    oPM_WriteLast,
   output logic                    oPM_WriteValid,
   input  logic                    iPM_WriteReady,
   input  logic [15:0]             iPM_ReadData,
   input  logic                    iPM_ReadValid,
   output logic                    oPM_ReadReady
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CA   = 3'd1,
      S_WDAT = 3'd2,
      S_RDAT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;

   logic [1:0]              r_op;
   logic [2:0]              r_ca_num;
   logic [NumberOfWays-1:0] r_way;
   logic [15:0]             r_num;
   logic                    r_ca_sel;
   logic [39:0]             r_ca_data;
   logic [2:0]              r_ca_idx;
   logic [15:0]             r_count;
   logic                    r_error;

   logic                    w_accept;
   logic                    w_legal;
   logic [2:0]              w_opt_clamped;
   logic                    w_ca_beat;
   logic                    w_ca_last;
   logic                    w_data_last;
   logic                    w_wr_beat;
   logic                    w_rd_beat;
   logic [7:0]              w_ca_byte;

   // Data phase that follows the CA bytes (or the accept, when there are none).
   function automatic state_t data_phase(input logic [1:0] op, input logic [15:0] num);
      if (num == 16'd0)    return S_DONE;
      else if (op == 2'd2) return S_WDAT;
      else if (op == 2'd3) return S_RDAT;
      else                 return S_DONE;
   endfunction

   assign w_accept      = (r_state == S_IDLE) && (iACG_Command != 8'h00);
   assign w_legal       = (iACG_Command == 8'h01) || (iACG_Command == 8'h02) ||
                          (iACG_Command == 8'h03);
   assign w_opt_clamped = (iACG_CommandOption > 3'd5) ? 3'd5 : iACG_CommandOption;
   assign w_ca_beat     = (r_state == S_CA) && iPM_CAReady;
   assign w_ca_last     = (r_ca_idx == (r_ca_num - 3'd1));
   assign w_data_last   = (r_count == (r_num - 16'd1));
   assign w_wr_beat     = (r_state == S_WDAT) && iACG_WriteValid && iPM_WriteReady;
   assign w_rd_beat     = (r_state == S_RDAT) && iPM_ReadValid && iACG_ReadReady;

   // Select the CA byte currently being offered, LSB byte first.
   always_comb begin
      w_ca_byte = 8'h00;
      case (r_ca_idx)
         3'd0:    w_ca_byte = r_ca_data[7:0];
         3'd1:    w_ca_byte = r_ca_data[15:8];
         3'd2:    w_ca_byte = r_ca_data[23:16];
         3'd3:    w_ca_byte = r_ca_data[31:24];
         3'd4:    w_ca_byte = r_ca_data[39:32];
         default: w_ca_byte = 8'h00;
      endcase
   end

   // State register.
   always_ff @(posedge iSystemClock or posedge iReset) begin
      if (iReset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!w_legal)                   w_next_state = S_DONE;
               else if (w_opt_clamped != 3'd0) w_next_state = S_CA;
               else w_next_state = data_phase(iACG_Command[1:0], iACG_NumOfData);
            end
         end
         S_CA:    if (w_ca_beat && w_ca_last)   w_next_state = data_phase(r_op, r_num);
         S_WDAT:  if (w_wr_beat && w_data_last) w_next_state = S_DONE;
         S_RDAT:  if (w_rd_beat && w_data_last) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Outputs; handshakes are zero outside their own state and valid never looks at ready.
   always_comb begin
      oACG_Ready      = (r_state == S_IDLE);
      oACG_Done       = (r_state == S_DONE);
      oACG_Error      = r_error;
      oPM_TargetWay   = (r_state == S_IDLE) ? '0 : r_way;
      oPM_CAValid     = 1'b0;
      oPM_CAData      = 8'h00;
      oPM_CAIsCmd     = 1'b0;
      oPM_WriteData   = 16'h0000;
      oPM_WriteLast   = 1'b0;
      oPM_WriteValid  = 1'b0;
      oACG_WriteReady = 1'b0;
      oACG_ReadData   = 16'h0000;
      oACG_ReadLast   = 1'b0;
      oACG_ReadValid  = 1'b0;
      oPM_ReadReady   = 1'b0;
      case (r_state)
         S_CA: begin
            oPM_CAValid = 1'b1;
            oPM_CAData  = w_ca_byte;
            oPM_CAIsCmd = r_ca_sel && (r_ca_idx == 3'd0);
         end
         S_WDAT: begin
            oPM_WriteValid  = iACG_WriteValid;
            oPM_WriteData   = iACG_WriteData;
            oPM_WriteLast   = w_data_last;
            oACG_WriteReady = iPM_WriteReady;
         end
         S_RDAT: begin
            oACG_ReadValid = iPM_ReadValid;
            oACG_ReadData  = iPM_ReadData;
            oACG_ReadLast  = w_data_last;
            oPM_ReadReady  = iACG_ReadReady;
         end
         default: ;
      endcase
   end

   // Command latch, CA byte index, beat counter and sticky error.
   always_ff @(posedge iSystemClock or posedge iReset) begin
      if (iReset) begin
         r_op      <= 2'd0;
         r_ca_num  <= 3'd0;
         r_way     <= '0;
         r_num     <= 16'd0;
         r_ca_sel  <= 1'b0;
         r_ca_data <= 40'd0;
         r_ca_idx  <= 3'd0;
         r_count   <= 16'd0;
         r_error   <= 1'b0;
      end else if (w_accept) begin
         // An illegal opcode latches a null command so no way is presented to the PHY.
         r_op      <= w_legal ? iACG_Command[1:0] : 2'd0;
         r_ca_num  <= w_legal ? w_opt_clamped : 3'd0;
         r_way     <= w_legal ? iACG_TargetWay : '0;
         r_num     <= iACG_NumOfData;
         r_ca_sel  <= iACG_CASelect;
         r_ca_data <= iACG_CAData;
         r_ca_idx  <= 3'd0;
         r_count   <= 16'd0;
         r_error   <= !w_legal;
      end else begin
         if (w_ca_beat) r_ca_idx <= r_ca_idx + 3'd1;
         if (w_wr_beat || w_rd_beat) r_count <= r_count + 16'd1;
`ifdef NFC_ACG_LAST_CHECK_EN
         if (w_wr_beat && (iACG_WriteLast != w_data_last)) r_error <= 1'b1;
`endif
      end
   end

`ifndef NFC_ACG_LAST_CHECK_EN
   // Upstream last flag has no consumer when the check is compiled out.
   logic w_unused_write_last;
   assign w_unused_write_last = iACG_WriteLast;
`endif

endmodule
